// File: rtl/adc_window_mon.sv
// Windowed ADC monitor: accumulates 2^LOG_WIN strobed samples and reports
// mean, min, max and full-scale clip count once per window.
module adc_window_mon #(
    parameter int unsigned LOG_WIN = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               strobe,
    input  logic [15:0]        adc,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic [15:0]        mean,
    output logic [15:0]        min,
    output logic [15:0]        max,
    output logic [LOG_WIN:0]   clip_cnt
);

    localparam int unsigned SUMW = 16 + LOG_WIN;
    localparam logic [LOG_WIN:0] CNT_LAST = (LOG_WIN + 1)'((1 << LOG_WIN) - 1);

    typedef enum logic [1:0] {IDLE, ACC, FIN} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic signed [SUMW-1:0]  r_sum;
    logic [LOG_WIN:0]        r_cnt;
    logic [LOG_WIN:0]        r_clip;
    logic signed [15:0]      r_min_run;
    logic signed [15:0]      r_max_run;
    logic                    r_done;
    logic [15:0]             r_mean;
    logic [15:0]             r_min;
    logic [15:0]             r_max;
    logic [LOG_WIN:0]        r_clip_out;

    logic                    w_begin;
    logic                    w_accept;
    logic                    w_last;
    logic                    w_clip;
    logic signed [15:0]      w_adc;
    logic signed [SUMW-1:0]  w_adc_ext;
    logic signed [SUMW-1:0]  w_mean_full;

    assign w_adc       = adc;
    assign w_adc_ext   = SUMW'(w_adc);
    assign w_begin     = (r_state == IDLE) && start && !abort;
    // abort wins over a coincident sample, including the final one
    assign w_accept    = (r_state == ACC) && strobe && !abort;
    assign w_last      = w_accept && (r_cnt == CNT_LAST);
    assign w_clip      = (adc == 16'h7FFC) || (adc == 16'h8000);
    assign w_mean_full = r_sum >>> LOG_WIN;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (w_begin) w_next = ACC;
            ACC: begin
                if (abort) begin
                    w_next = IDLE;
                end else if (w_last) begin
                    w_next = FIN;
                end
            end
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == ACC);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum      <= '0;
            r_cnt      <= '0;
            r_clip     <= '0;
            r_min_run  <= '0;
            r_max_run  <= '0;
            r_done     <= 1'b0;
            r_mean     <= '0;
            r_min      <= '0;
            r_max      <= '0;
            r_clip_out <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_begin) begin
                r_sum     <= '0;
                r_cnt     <= '0;
                r_clip    <= '0;
                r_min_run <= 16'sh7FFF;
                r_max_run <= -16'sh8000;
            end else if (w_accept) begin
                r_sum <= r_sum + w_adc_ext;
                r_cnt <= r_cnt + 1'b1;
                if (w_clip) r_clip <= r_clip + 1'b1;
                if (w_adc < r_min_run) r_min_run <= w_adc;
                if (w_adc > r_max_run) r_max_run <= w_adc;
            end else if (r_state == FIN) begin
                r_done     <= 1'b1;
                r_mean     <= w_mean_full[15:0];
                r_min      <= r_min_run;
                r_max      <= r_max_run;
                r_clip_out <= r_clip;
            end
        end
    end

    assign done     = r_done;
    assign mean     = r_mean;
    assign min      = r_min;
    assign max      = r_max;
    assign clip_cnt = r_clip_out;

endmodule

// File: tb/tb_adc_window_mon.sv
// Directed bench for adc_window_mon with LOG_WIN=4: table of 16-sample
// windows plus hand sequences for abort, abort-in-FIN and mid-window reset.
module tb_adc_window_mon;

    localparam int unsigned LW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          strobe;
    logic [15:0]   adc;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic [15:0]   mean;
    logic [15:0]   min;
    logic [15:0]   max;
    logic [LW:0]   clip_cnt;

    adc_window_mon #(.LOG_WIN(LW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .strobe   (strobe),
        .adc      (adc),
        .start    (start),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .mean     (mean),
        .min      (min),
        .max      (max),
        .clip_cnt (clip_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0][15:0] smp;
        int                gap;
        bit                mid_start;
        bit                fin_abort;
        int                e_mean;
        int                e_min;
        int                e_max;
        int                e_clip;
    } vec_t;

    vec_t vecs [6];
    int   checks = 0;
    int   errors = 0;
    int   exp_mean = 0, exp_min = 0, exp_max = 0, exp_clip = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic chk_results(input string tag);
        chk({tag, "_mean"}, int'($signed(mean)), exp_mean);
        chk({tag, "_min"},  int'($signed(min)),  exp_min);
        chk({tag, "_max"},  int'($signed(max)),  exp_max);
        chk({tag, "_clip"}, int'(clip_cnt),      exp_clip);
    endtask

    task automatic run_window(input int k);
        vec_t v;
        bit   bad;
        v   = vecs[k];
        bad = 1'b0;
        // strobe during the start cycle carries a poison sample that must be ignored
        start  = 1'b1;
        strobe = 1'b1;
        adc    = 16'h8000;
        tick();
        chk($sformatf("v%0d_busy_start", k), int'(busy), 1);
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            for (int g = 0; g < v.gap; g++) begin
                strobe = 1'b0;
                start  = v.mid_start && (i == 8);
                tick();
                if (done || !busy) bad = 1'b1;
            end
            start  = 1'b0;
            strobe = 1'b1;
            adc    = v.smp[i];
            tick();
            if (i < 15 && (done || !busy)) bad = 1'b1;
        end
        strobe = 1'b0;
        abort  = v.fin_abort;
        chk($sformatf("v%0d_window_len", k), int'(bad), 0);
        chk($sformatf("v%0d_fin_busy", k), int'(busy), 0);
        chk($sformatf("v%0d_fin_done", k), int'(done), 0);
        chk_results($sformatf("v%0d_hold", k));
        tick();
        abort = 1'b0;
        chk($sformatf("v%0d_done", k), int'(done), 1);
        exp_mean = v.e_mean;
        exp_min  = v.e_min;
        exp_max  = v.e_max;
        exp_clip = v.e_clip;
        chk_results($sformatf("v%0d", k));
        tick();
        chk($sformatf("v%0d_done_pulse", k), int'(done), 0);
        chk($sformatf("v%0d_idle_busy", k), int'(busy), 0);
    endtask

    initial begin
        bit seen;

        for (int i = 0; i < 16; i++) begin
            vecs[0].smp[i] = 16'h0100;
            vecs[1].smp[i] = (i % 2 == 0) ? 16'h7FFC : 16'h8000;
            vecs[2].smp[i] = 16'((i - 8) * 4);
            vecs[3].smp[i] = 16'((i - 8) * 4);
            vecs[4].smp[i] = (i == 6) ? 16'h7FFC : 16'hFFFC;
            vecs[5].smp[i] = 16'h8000;
        end
        vecs[0].gap = 0; vecs[0].mid_start = 0; vecs[0].fin_abort = 0;
        vecs[0].e_mean = 256;    vecs[0].e_min = 256;    vecs[0].e_max = 256;   vecs[0].e_clip = 0;
        vecs[1].gap = 0; vecs[1].mid_start = 0; vecs[1].fin_abort = 0;
        vecs[1].e_mean = -2;     vecs[1].e_min = -32768; vecs[1].e_max = 32764; vecs[1].e_clip = 16;
        vecs[2].gap = 0; vecs[2].mid_start = 0; vecs[2].fin_abort = 0;
        vecs[2].e_mean = -2;     vecs[2].e_min = -32;    vecs[2].e_max = 28;    vecs[2].e_clip = 0;
        vecs[3].gap = 2; vecs[3].mid_start = 1; vecs[3].fin_abort = 0;
        vecs[3].e_mean = -2;     vecs[3].e_min = -32;    vecs[3].e_max = 28;    vecs[3].e_clip = 0;
        vecs[4].gap = 1; vecs[4].mid_start = 0; vecs[4].fin_abort = 1;
        vecs[4].e_mean = 2044;   vecs[4].e_min = -4;     vecs[4].e_max = 32764; vecs[4].e_clip = 1;
        vecs[5].gap = 0; vecs[5].mid_start = 0; vecs[5].fin_abort = 0;
        vecs[5].e_mean = -32768; vecs[5].e_min = -32768; vecs[5].e_max = -32768; vecs[5].e_clip = 16;

        rst_n  = 1'b0;
        strobe = 1'b0;
        adc    = '0;
        start  = 1'b0;
        abort  = 1'b0;
        repeat (3) tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk_results("rst");
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 6; k++) run_window(k);

        // abort coinciding with sample 9, a start and a clip code
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            strobe = 1'b1;
            adc    = 16'h1234;
            tick();
        end
        adc   = 16'h7FFC;
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort  = 1'b0;
        start  = 1'b0;
        strobe = 1'b0;
        chk("abort_busy", int'(busy), 0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            strobe = 1'b1;
            tick();
            if (done || busy) seen = 1'b1;
        end
        strobe = 1'b0;
        chk("abort_no_done", int'(seen), 0);
        chk_results("abort_hold");
        run_window(0);

        // reset after 5 samples of a window
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            strobe = 1'b1;
            adc    = 16'h7FFC;
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        exp_mean = 0; exp_min = 0; exp_max = 0; exp_clip = 0;
        chk_results("midrst");
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done || busy) seen = 1'b1;
        end
        strobe = 1'b0;
        chk("midrst_no_done", int'(seen), 0);
        run_window(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/adc_window_mon.md
ADC_WINDOW_MON -- requirements
Module: adc_window_mon

Interface
REQ-001 The block SHALL have parameter LOG_WIN, default 10, giving window length 2^LOG_WIN strobed samples; legal range 1..16.
REQ-002 The block SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-004 The block SHALL have port strobe, input, 1, sample-valid qualifier on adc.
REQ-005 The block SHALL have port adc, input, 16, signed sample: 14-bit converter value left-justified, bits [1:0] zero.
REQ-006 The block SHALL have port start, input, 1, single-cycle request to begin one window.
REQ-007 The block SHALL have port abort, input, 1, cancels a window in progress.
REQ-008 The block SHALL have port busy, output, 1, high while a window is being accumulated.
REQ-009 The block SHALL have port done, output, 1, one-cycle pulse when new results load.
REQ-010 The block SHALL have port mean, output, 16, signed window mean.
REQ-011 The block SHALL have ports min and max, output, 16 each, signed window extremes.
REQ-012 The block SHALL have port clip_cnt, output, LOG_WIN+1, count of clipped samples in window.

Function
REQ-013 The block SHALL implement states IDLE, ACC and FIN; busy = (state==ACC).
REQ-014 In IDLE, start=1 and abort=0 SHALL move to ACC at the next edge, clearing sum, sample counter and clip counter, and setting running min to +32767 and running max to -32768.
REQ-015 A sample SHALL be accepted only on an edge where state==ACC and strobe=1; strobe in the start cycle is not accepted.
REQ-016 On each accepted sample: sum += adc, sign-extended to 16+LOG_WIN bits with no overflow possible; running min/max update; counter increments.
REQ-017 A sample SHALL count as clipped when adc==16'h7FFC or adc==16'h8000, the 14-bit full-scale codes.
REQ-018 The edge accepting sample number 2^LOG_WIN SHALL move state to FIN; counter width LOG_WIN+1, no wrap before this.
REQ-019 In FIN the next edge SHALL load mean = sum >>> LOG_WIN (arithmetic, floor toward -inf), min, max and clip_cnt, SHALL assert done for exactly that following cycle, and SHALL return to IDLE.
REQ-020 Result latency SHALL be: done high in the cycle after the FIN cycle, i.e. 2 clocks after the edge accepting the last sample.
REQ-021 Outputs mean/min/max/clip_cnt SHALL hold their last loaded values until the next done; they SHALL NOT change mid-window.
REQ-022 start while in ACC or FIN SHALL be ignored, with no restart and no queueing.
REQ-023 abort=1 in ACC SHALL return to IDLE at the next edge with no done, results unchanged; abort takes priority over a coincident final sample and over start.
REQ-024 abort in FIN SHALL be ignored; the window completes.
REQ-025 Gaps in strobe SHALL only stretch the window; there is no timeout.

Reset
REQ-026 When rst_n=0 at an edge, the state SHALL be IDLE and busy, done, mean, min, max and clip_cnt SHALL be 0, and internal accumulators SHALL be cleared, regardless of current state.
REQ-027 The first start after rst_n returns to 1 SHALL behave as REQ-014.

Verification (LOG_WIN=4, 16 samples)
REQ-028 Constant adc=16'h0100, strobe=1 continuously, start pulse -> busy 16 cycles, done 2 clocks after the 16th sample, mean=256, min=max=256, clip_cnt=0.
REQ-029 Alternating 16'h7FFC/16'h8000, 8 each -> clip_cnt=16, min=-32768, max=32764, mean=-2.
REQ-030 Ramp adc=-8..7 times 4, i.e. 16'hFFE0 to 16'h001C; sum=-32 -> mean=-2 (floor check); min=-32, max=28.
REQ-031 strobe every third cycle -> exactly 16 accepted samples, done after 16th strobe; start pulses mid-window have no effect.
REQ-032 abort at sample 9 -> busy low next cycle, no done, outputs retain previous window values; a new start then yields a full correct window.
REQ-033 rst_n=0 for 1 cycle at sample 5 -> all outputs 0, state IDLE; no done follows until a new start.
